shift_rows_pipe: RTL and testbench

//  Parametrised, pipelined AES/Rijndael ShiftRows / InvShiftRows stage with valid/ready flow control.

---
 rtl/shift_rows_pipe.sv | 134 +++++++++++++
 tb/tb_shift_rows_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Pipelined AES ShiftRows / InvShiftRows stage (Nb = 4/6/8) with valid/ready flow control.
// Optional sideband tag per beat when SHIFTROWS_TAG_EN is defined.
module shift_rows_pipe #(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [32*NB-1:0]    data_in,
`ifdef SHIFTROWS_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    out_tag,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_inv,
    output logic [32*NB-1:0]    data_out
);

    localparam int unsigned W    = 32 * NB;
    localparam int unsigned LAST = STAGES - 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be >= 1");
    end

    logic [W-1:0]        w_perm;
    logic [STAGES:0]     w_rdy;
    logic [STAGES-1:0]   w_src_v;
    logic [STAGES-1:0]   w_src_inv;
    logic [W-1:0]        w_src_data [STAGES];
    logic [STAGES-1:0]   r_v;
    logic [STAGES-1:0]   r_inv;
    logic [W-1:0]        r_data [STAGES];
`ifdef SHIFTROWS_TAG_EN
    logic [TAG_W-1:0]    w_src_tag [STAGES];
    logic [TAG_W-1:0]    r_tag [STAGES];
`endif

    // Byte permutation; rows 2/3 use offsets 3/4 for the 256-bit block.
    always_comb begin : permute
        int off;
        int sc;
        w_perm = '0;
        off    = 0;
        sc     = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < int'(NB); c++) begin
                off = (NB == 8 && r >= 2) ? r + 1 : r;
                sc  = in_inv ? (c + int'(NB) - off) % int'(NB) : (c + off) % int'(NB);
                w_perm[W-1-8*(NB*r+c) -: 8] = data_in[W-1-8*(NB*r+sc) -: 8];
            end
        end
    end

    // Ready ripples back from the output so empty stages collapse.
    always_comb begin : ready_chain
        logic acc;
        acc           = out_ready;
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            acc      = ~r_v[k] | acc;
            w_rdy[k] = acc;
        end
    end

    assign in_ready = rst_n & ~flush & w_rdy[0];

    always_comb begin : stage_src
        w_src_v[0]    = in_valid & in_ready;
        w_src_inv[0]  = in_inv;
        w_src_data[0] = w_perm;
`ifdef SHIFTROWS_TAG_EN
        w_src_tag[0]  = in_tag;
`endif
        for (int k = 1; k < int'(STAGES); k++) begin
            w_src_v[k]    = r_v[k-1];
            w_src_inv[k]  = r_inv[k-1];
            w_src_data[k] = r_data[k-1];
`ifdef SHIFTROWS_TAG_EN
            w_src_tag[k]  = r_tag[k-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_inv <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                r_data[k] <= '0;
`ifdef SHIFTROWS_TAG_EN
                r_tag[k]  <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (flush) begin
                    r_v[k] <= 1'b0;
                end else if (w_rdy[k]) begin
                    r_v[k] <= w_src_v[k];
                end
                // Payload only moves with a real beat; empty-stage contents are don't-care.
                if (w_rdy[k] && w_src_v[k]) begin
                    r_inv[k]  <= w_src_inv[k];
                    r_data[k] <= w_src_data[k];
`ifdef SHIFTROWS_TAG_EN
                    r_tag[k]  <= w_src_tag[k];
`endif
                end
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign out_inv   = r_v[LAST] & r_inv[LAST];
    assign data_out  = r_v[LAST] ? r_data[LAST] : '0;
`ifdef SHIFTROWS_TAG_EN
    assign out_tag   = r_v[LAST] ? r_tag[LAST] : '0;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4/STAGES=1, NB=8/STAGES=2 and NB=4/STAGES=3 instances.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [127:0] a_din, a_dout;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [255:0] b_din, b_dout;
    logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
    logic [127:0] c_din, c_dout;
`ifdef SHIFTROWS_TAG_EN
    logic [3:0]   a_in_tag, a_out_tag, b_in_tag, b_out_tag, c_in_tag, c_out_tag;
`endif

    localparam logic [127:0] T1_IN  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] T1_EXP = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
    localparam logic [255:0] B_IN   = 256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F;
    localparam logic [255:0] B_EXP  = 256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .data_in(a_din),
`ifdef SHIFTROWS_TAG_EN
        .in_tag(a_in_tag), .out_tag(a_out_tag),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv), .data_out(a_dout)
    );

    shift_rows_pipe #(.NB(8), .STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .data_in(b_din),
`ifdef SHIFTROWS_TAG_EN
        .in_tag(b_in_tag), .out_tag(b_out_tag),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv), .data_out(b_dout)
    );

    shift_rows_pipe #(.NB(4), .STAGES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv), .data_in(c_din),
`ifdef SHIFTROWS_TAG_EN
        .in_tag(c_in_tag), .out_tag(c_out_tag),
`endif
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_inv(c_out_inv), .data_out(c_dout)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // NB=4 reference: each row is a 32-bit word rotated by its row index in bytes.
    function automatic logic [127:0] m4(input logic [127:0] d, input logic inv);
        logic [63:0]  dd;
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            dd = {d[127-32*r -: 32], d[127-32*r -: 32]};
            o[127-32*r -: 32] = inv ? dd[63-8*(4-r) -: 32] : dd[63-8*r -: 32];
        end
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] vec [10];
        logic [127:0] held;
        rst_n = 1'b0; flush = 1'b0;
        a_in_valid = 0; a_in_inv = 0; a_din = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_inv = 0; b_din = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_inv = 0; c_din = '0; c_out_ready = 0;
`ifdef SHIFTROWS_TAG_EN
        a_in_tag = '0; b_in_tag = '0; c_in_tag = '0;
`endif
        for (int i = 0; i < 10; i++) vec[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

        // Reset state
        #2;
        chk("rst_in_ready", 256'(a_in_ready), 256'(0));
        chk("rst_a_valid", 256'(a_out_valid), 256'(0));
        chk("rst_a_data", 256'(a_dout), 256'(0));
        chk("rst_b_data", b_dout, 256'(0));
        chk("rst_c_valid", 256'(c_out_valid), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 256'(a_in_ready), 256'(1));

        // NB=4 forward, one-cycle latency
        a_out_ready = 1; a_in_valid = 1; a_din = T1_IN; a_in_inv = 0;
        step();
        a_in_valid = 0;
        chk("t1_valid", 256'(a_out_valid), 256'(1));
        chk("t1_data", 256'(a_dout), 256'(T1_EXP));
        chk("t1_inv", 256'(a_out_inv), 256'(0));
        step();
        chk("t1_idle_valid", 256'(a_out_valid), 256'(0));
        chk("t1_idle_data", 256'(a_dout), 256'(0));

        // NB=4 inverse restores the original
        a_in_valid = 1; a_din = T1_EXP; a_in_inv = 1;
        step();
        a_in_valid = 0;
        chk("t2_data", 256'(a_dout), 256'(T1_IN));
        chk("t2_inv", 256'(a_out_inv), 256'(1));
        step();

        // NB=8 forward through two stages
        b_out_ready = 1; b_in_valid = 1; b_din = B_IN; b_in_inv = 0;
        step();
        b_in_valid = 0;
        chk("t3_lat1_valid", 256'(b_out_valid), 256'(0));
        step();
        chk("t3_valid", 256'(b_out_valid), 256'(1));
        chk("t3_data", b_dout, B_EXP);
        step();
        chk("t3_idle", 256'(b_out_valid), 256'(0));

        // NB=8 stall with full pipe, then release
        b_out_ready = 0; b_in_valid = 1; b_din = B_IN; b_in_inv = 0;
        step();
        b_din = B_EXP; b_in_inv = 1;
        step();
        b_din = {32{8'hA5}}; b_in_inv = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_ready", 256'(b_in_ready), 256'(0));
            chk("t5_stall_valid", 256'(b_out_valid), 256'(1));
            chk("t5_stall_data", b_dout, B_EXP);
            step();
        end
        b_out_ready = 1;
        #1;
        chk("t5_release_ready", 256'(b_in_ready), 256'(1));
        step();
        b_in_valid = 0;
        chk("t5_beat2_data", b_dout, B_IN);
        chk("t5_beat2_inv", 256'(b_out_inv), 256'(1));
        step();
        chk("t5_beat3_data", b_dout, {32{8'hA5}});
        step();
        chk("t5_drained", 256'(b_out_valid), 256'(0));

        // STAGES=3 back-to-back beats alternating direction
        c_out_ready = 1;
        for (int m = 0; m < 14; m++) begin
            if (m >= 3 && m < 13) begin
                chk("t4_valid", 256'(c_out_valid), 256'(1));
                chk("t4_data", 256'(c_dout), 256'(m4(vec[m-3], (m - 3) % 2 == 1)));
                chk("t4_inv", 256'(c_out_inv), 256'((m - 3) % 2));
`ifdef SHIFTROWS_TAG_EN
                chk("t4_tag", 256'(c_out_tag), 256'(m - 3));
`endif
            end else begin
                chk("t4_gap_valid", 256'(c_out_valid), 256'(0));
            end
            if (m < 10) begin
                c_in_valid = 1; c_din = vec[m]; c_in_inv = (m % 2 == 1);
`ifdef SHIFTROWS_TAG_EN
                c_in_tag = 4'(m);
`endif
            end else begin
                c_in_valid = 0;
            end
            step();
        end

        // Asynchronous reset mid-stream
        c_in_valid = 1; c_din = vec[0]; c_in_inv = 0;
        step();
        step();
        step();
        chk("t6_pre_rst_valid", 256'(c_out_valid), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 256'(c_out_valid), 256'(0));
        chk("t6_rst_data", 256'(c_dout), 256'(0));
        chk("t6_rst_ready", 256'(c_in_ready), 256'(0));
        c_in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        c_in_valid = 1; c_din = vec[5]; c_in_inv = 1;
        step();
        c_in_valid = 0;
        chk("t6_lat1", 256'(c_out_valid), 256'(0));
        step();
        chk("t6_lat2", 256'(c_out_valid), 256'(0));
        step();
        chk("t6_lat3_valid", 256'(c_out_valid), 256'(1));
        chk("t6_lat3_data", 256'(c_dout), 256'(m4(vec[5], 1'b1)));
        step();

        // Flush a partly full stalled pipe together with an offered beat
        c_out_ready = 0; c_in_valid = 1; c_din = vec[1]; c_in_inv = 0;
        step();
        c_din = vec[2];
        step();
        c_in_valid = 0;
        step();
        held = m4(vec[1], 1'b0);
        chk("t7_pre_flush", 256'(c_dout), 256'(held));
        flush = 1; c_in_valid = 1; c_din = vec[3];
        #1;
        chk("t7_flush_ready", 256'(c_in_ready), 256'(0));
        step();
        flush = 0; c_in_valid = 0; c_out_ready = 1;
        chk("t7_flush_data", 256'(c_dout), 256'(0));
        for (int i = 0; i < 4; i++) begin
            chk("t7_flush_empty", 256'(c_out_valid), 256'(0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
